sik_fetch: RTL and testbench

- Instruction-fetch stage of the two-thread pipelined SIK stack processor. Sits directly upstream of decode.
- Alternates fetch slots between thread 0 and thread 1, reads instruction memory with a 1-cycle synchronous latency and folds OPpre prefixes into a resolved 16-bit immediate.
- Hands decode one tagged instruction per cycle, or a bubble.
- Accepts per-thread redirects and halts from execute.

---
 rtl/sik_fetch_pkg.sv | 33 +++
 rtl/sik_fetch_if.sv | 40 ++++
 rtl/sik_prefix_fold.sv | 53 +++++
 rtl/sik_fetch.sv | 125 ++++++++++++
 tb/tb_sik_fetch.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sik_fetch_pkg.sv
// ============================================================================
// Module   : sik_fetch_pkg
// Brief    : Shared widths, opcode constants and immediate helper for SIK fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sik_fetch_pkg;

  localparam int WORD_W   = 16;
  localparam int OPCODE_W = 4;
  localparam int IMMED12_W = 12;
  localparam int PRE_W    = 4;
  localparam int TID_W    = 1;
  localparam int NTHREADS = 2;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [TID_W-1:0]    tid_t;
  typedef logic [PRE_W-1:0]    pre_t;
  typedef logic [IMMED12_W-1:0] immed12_t;

  localparam opcode_t OP_PUSH = 4'b1000;
  localparam opcode_t OP_PRE  = 4'b1111;

  // A pending prefix supplies the top nibble; otherwise the 12-bit field is sign-extended.
  function automatic word_t resolve_immed(input logic loaded, input pre_t pre, input immed12_t imm);
    return loaded ? {pre, imm} : {{(WORD_W-IMMED12_W){imm[IMMED12_W-1]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sik_fetch_if.sv
// ============================================================================
// Module   : sik_fetch_if
// Brief    : Control, instruction-memory and decode-side signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sik_fetch_if;
  import sik_fetch_pkg::*;

  logic       stall;
  logic       redirect_valid;
  tid_t       redirect_tid;
  word_t      redirect_pc;
  logic [1:0] halt_req;

  logic       imem_en;
  word_t      imem_addr;
  word_t      imem_data;

  logic       out_valid;
  tid_t       out_tid;
  word_t      out_pc;
  word_t      out_ir;
  word_t      out_immed;
  logic       halted;

  modport master (
    input  stall, redirect_valid, redirect_tid, redirect_pc, halt_req, imem_data,
    output imem_en, imem_addr, out_valid, out_tid, out_pc, out_ir, out_immed, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_tid, redirect_pc, halt_req, imem_data,
    input  imem_en, imem_addr, out_valid, out_tid, out_pc, out_ir, out_immed, halted
  );

endinterface

`default_nettype wire

// File: rtl/sik_prefix_fold.sv
// ============================================================================
// Module   : sik_prefix_fold
// Brief    : Per-thread OPpre state and the immediate-resolve mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sik_prefix_fold
  import sik_fetch_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  input  wire logic     i_load,
  input  wire tid_t     i_load_tid,
  input  wire pre_t     i_pre,
  input  wire logic     i_clear,
  input  wire tid_t     i_clear_tid,
  input  wire logic     i_redir,
  input  wire tid_t     i_redir_tid,
  input  wire tid_t     i_tid,
  input  wire immed12_t i_imm12,
  output word_t         o_immed
);

  logic [NTHREADS-1:0] r_loaded;
  pre_t                r_preload [NTHREADS];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_loaded <= '0;
      for (int t = 0; t < NTHREADS; t++) begin
        r_preload[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        // A redirect discards any half-built immediate of that thread.
        if (i_redir && (i_redir_tid == tid_t'(t))) begin
          r_loaded[t] <= 1'b0;
        end else if (i_load && (i_load_tid == tid_t'(t))) begin
          r_loaded[t]  <= 1'b1;
          r_preload[t] <= i_pre;
        end else if (i_clear && (i_clear_tid == tid_t'(t))) begin
          r_loaded[t] <= 1'b0;
        end
      end
    end
  end

  assign o_immed = resolve_immed(r_loaded[i_tid], r_preload[i_tid], i_imm12);

endmodule

`default_nettype wire

// File: rtl/sik_fetch.sv
// ============================================================================
// Module   : sik_fetch
// Brief    : Two-thread interleaved instruction fetch with OPpre folding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sik_fetch
  import sik_fetch_pkg::*;
#(
  parameter word_t   PC_T0  = 16'h0000,
  parameter word_t   PC_T1  = 16'h8000,
  parameter opcode_t OP_PRE = 4'b1111
) (
  input  wire logic   clk,
  input  wire logic   reset,
  sik_fetch_if.master bus
);

  tid_t       r_sel;
  word_t      r_pc [NTHREADS];
  logic [1:0] r_hstate;
  logic       r_halted;

  logic       r_if_valid;
  tid_t       r_if_tid;
  word_t      r_if_pc;

  logic       r_out_valid;
  tid_t       r_out_tid;
  word_t      r_out_pc;
  word_t      r_out_ir;
  word_t      r_out_immed;

  logic       w_issue;
  logic       w_redir_sel;
  logic       w_if_hit;
  logic       w_ret_valid;
  logic       w_is_pre;
  logic [1:0] w_hstate_nxt;
  word_t      w_immed;

  always_comb begin
    w_issue      = !bus.stall && !r_hstate[r_sel];
    w_redir_sel  = bus.redirect_valid && (bus.redirect_tid == r_sel);
    // The word coming back is dropped if its thread is redirected or halting.
    w_if_hit     = (bus.redirect_valid && (bus.redirect_tid == r_if_tid)) ||
                   r_hstate[r_if_tid] || bus.halt_req[r_if_tid];
    w_ret_valid  = r_if_valid && !w_if_hit;
    w_is_pre     = w_ret_valid && (bus.imem_data[15:12] == OP_PRE);
    w_hstate_nxt = r_hstate | bus.halt_req;
  end

  sik_prefix_fold u_fold (
    .clk         (clk),
    .reset       (reset),
    .i_load      (!bus.stall && w_is_pre),
    .i_load_tid  (r_if_tid),
    .i_pre       (bus.imem_data[3:0]),
    .i_clear     (!bus.stall && w_ret_valid && !w_is_pre),
    .i_clear_tid (r_if_tid),
    .i_redir     (bus.redirect_valid),
    .i_redir_tid (bus.redirect_tid),
    .i_tid       (r_if_tid),
    .i_imm12     (bus.imem_data[11:0]),
    .o_immed     (w_immed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel       <= '0;
      r_pc[0]     <= PC_T0;
      r_pc[1]     <= PC_T1;
      r_hstate    <= '0;
      r_halted    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_if_tid    <= '0;
      r_if_pc     <= '0;
      r_out_valid <= 1'b0;
      r_out_tid   <= '0;
      r_out_pc    <= '0;
      r_out_ir    <= '0;
      r_out_immed <= '0;
    end else begin
      r_hstate <= w_hstate_nxt;
      r_halted <= &w_hstate_nxt;
      if (!bus.stall) begin
        r_if_valid <= w_issue && !w_redir_sel;
        r_if_tid   <= r_sel;
        r_if_pc    <= r_pc[r_sel];
        if (w_issue) begin
          r_pc[r_sel] <= r_pc[r_sel] + 16'd1;
        end
        r_sel <= ~r_sel;
        if (w_is_pre) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= w_ret_valid;
          r_out_tid   <= r_if_tid;
          r_out_pc    <= r_if_pc;
          r_out_ir    <= bus.imem_data;
          r_out_immed <= w_immed;
        end
      end else begin
        r_if_valid <= r_if_valid && !w_if_hit;
      end
      // Placed last so a redirect overrides the slot's pc+1.
      if (bus.redirect_valid) begin
        r_pc[bus.redirect_tid] <= bus.redirect_pc;
      end
    end
  end

  assign bus.imem_en   = w_issue && !reset;
  assign bus.imem_addr = r_pc[r_sel];
  assign bus.out_valid = r_out_valid;
  assign bus.out_tid   = r_out_tid;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_ir    = r_out_ir;
  assign bus.out_immed = r_out_immed;
  assign bus.halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_sik_fetch.sv
// ============================================================================
// Module   : tb_sik_fetch
// Brief    : Directed and randomized checks of sik_fetch against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sik_fetch;
  import sik_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sik_fetch_if bus ();

  sik_fetch #(.PC_T0(16'h0000), .PC_T1(16'h8000), .OP_PRE(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [65536];
  logic [15:0] rdata = 16'h0000;
  always @(posedge clk) if (bus.imem_en) rdata <= mem[bus.imem_addr];
  assign bus.imem_data = rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rel    = 0;

  // Reference model state
  logic [15:0] m_pc [2];
  int          m_sel;
  bit   [1:0]  m_h;
  bit   [1:0]  m_ld;
  int          m_pre [2];
  bit          m_ifv;
  int          m_ift;
  logic [15:0] m_ifpc, m_ifw;
  bit          m_ov;
  int          m_ot;
  logic [15:0] m_opc, m_oir, m_oimm;
  bit          m_halted;

  typedef struct {
    int          tid;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] imm;
    int          cyc;
  } emit_t;
  emit_t log_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_immed(input bit loaded, input int pre, input logic [15:0] w);
    int v;
    v = int'(w[11:0]);
    if (loaded) return 16'(pre * 4096 + v);
    if (v >= 2048) v = v - 4096;
    return 16'(v);
  endfunction

  task automatic m_step(input bit st, input bit rv, input int rt, input logic [15:0] rpc,
                        input logic [1:0] hr, input bit rs);
    bit hit, iss;
    if (rs) begin
      m_pc[0] = 16'h0000; m_pc[1] = 16'h8000; m_sel = 0; m_h = 0; m_ld = 0;
      m_pre[0] = 0; m_pre[1] = 0; m_ifv = 0; m_ov = 0; m_ot = 0;
      m_opc = 0; m_oir = 0; m_oimm = 0; m_halted = 0;
      return;
    end
    hit = m_ifv && ((rv && rt == m_ift) || m_h[m_ift] || hr[m_ift]);
    if (!st) begin
      if (m_ifv && !hit && m_ifw[15:12] == 4'hF) begin
        m_ld[m_ift] = 1; m_pre[m_ift] = int'(m_ifw[3:0]); m_ov = 0;
      end else begin
        m_ov = m_ifv && !hit; m_ot = m_ift; m_opc = m_ifpc; m_oir = m_ifw;
        m_oimm = ref_immed(m_ld[m_ift], m_pre[m_ift], m_ifw);
        if (m_ov) m_ld[m_ift] = 0;
      end
      iss   = !m_h[m_sel];
      m_ifv = iss && !(rv && rt == m_sel);
      m_ift = m_sel; m_ifpc = m_pc[m_sel]; m_ifw = mem[m_pc[m_sel]];
      if (iss) m_pc[m_sel] = m_pc[m_sel] + 16'd1;
      m_sel = 1 - m_sel;
    end else if (hit) begin
      m_ifv = 0;
    end
    if (rv) begin m_pc[rt] = rpc; m_ld[rt] = 0; end
    m_h = m_h | hr;
    m_halted = &m_h;
  endtask

  task automatic cycle(input bit st, input bit rv, input int rt, input logic [15:0] rpc,
                       input logic [1:0] hr, input bit rs);
    bit en;
    reset = rs; bus.stall = st; bus.redirect_valid = rv; bus.redirect_tid = rt[0];
    bus.redirect_pc = rpc; bus.halt_req = hr;
    #1;
    en = !rs && !st && !m_h[m_sel];
    check_eq("imem_en", bus.imem_en, en);
    if (en) check_eq("imem_addr", bus.imem_addr, m_pc[m_sel]);
    @(posedge clk);
    cyc++;
    m_step(st, rv, rt, rpc, hr, rs);
    #1;
    check_eq("out_valid", bus.out_valid, m_ov);
    check_eq("halted", bus.halted, m_halted);
    if (m_ov) begin
      check_eq("out_tid", bus.out_tid, m_ot);
      check_eq("out_pc", bus.out_pc, m_opc);
      check_eq("out_ir", bus.out_ir, m_oir);
      check_eq("out_immed", bus.out_immed, m_oimm);
    end
    if (rs) begin
      check_eq("rst_out_tid", bus.out_tid, 0);
      check_eq("rst_out_pc", bus.out_pc, 0);
      check_eq("rst_out_ir", bus.out_ir, 0);
      check_eq("rst_out_immed", bus.out_immed, 0);
    end
    if (!rs && !st && m_ov) log_q.push_back('{m_ot, m_opc, m_oir, m_oimm, cyc});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0, 2'b00, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 16'h0, 2'b00, 1);
    cycle(0, 0, 0, 16'h0, 2'b00, 1);
    rel = cyc;
    log_q.delete();
  endtask

  function automatic int nth_tid(input int t, input int n);
    int k = 0;
    foreach (log_q[i]) if (log_q[i].tid == t) begin
      if (k == n) return i;
      k++;
    end
    return -1;
  endfunction

  // Each thread's emitted PCs must be consecutive from its start (no drop/duplicate).
  task automatic check_seq(input string tag, input int t, input logic [15:0] start);
    logic [15:0] e = start;
    foreach (log_q[i]) if (log_q[i].tid == t) begin
      check_eq(tag, log_q[i].pc, e);
      e = e + 16'd1;
    end
  endtask

  task automatic fill_base();
    for (int k = 0; k < 65536; k++) mem[k] = 16'h1000 | 16'(k);
  endtask

  initial begin
    int idx, cnt, hcyc;
    logic [15:0] w;
    reset = 1; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_tid = 0;
    bus.redirect_pc = 0; bus.halt_req = 0;
    fill_base();
    m_step(0, 0, 0, 16'h0, 2'b00, 1);
    @(negedge clk);

    // Free-run interleave
    do_reset();
    run(12);
    check_eq("a_count", (log_q.size() >= 4), 1);
    if (log_q.size() >= 4) begin
      check_eq("a_first_lat", log_q[0].cyc - rel, 2);
      check_eq("a_tid0", log_q[0].tid, 0);
      check_eq("a_tid1", log_q[1].tid, 1);
      check_eq("a_pc0", log_q[0].pc, 16'h0000);
      check_eq("a_pc1", log_q[1].pc, 16'h8000);
      check_eq("a_pc2", log_q[2].pc, 16'h0001);
      check_eq("a_pc3", log_q[3].pc, 16'h8001);
    end

    // Prefix fold, then a stall mid-stream
    mem[0] = 16'hF00A; mem[1] = 16'h8123; mem[2] = 16'h8FFF;
    do_reset();
    run(8);
    idx = nth_tid(0, 0);
    check_eq("b_found", (idx >= 0), 1);
    if (idx >= 0) begin
      check_eq("b_pc", log_q[idx].pc, 16'h0001);
      check_eq("b_immed", log_q[idx].imm, 16'hA123);
    end
    check_eq("b_bubble", log_q[0].tid, 1);
    idx = nth_tid(0, 1);
    check_eq("b2_found", (idx >= 0), 1);
    if (idx >= 0) check_eq("b2_immed", log_q[idx].imm, 16'hFFFF);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0, 2'b00, 0);
    run(8);
    check_seq("c_seq_t0", 0, 16'h0001);
    check_seq("c_seq_t1", 1, 16'h8000);
    fill_base();

    // Redirect with a T0 word in flight
    do_reset();
    run(1);
    cycle(0, 1, 0, 16'h0040, 2'b00, 0);
    run(8);
    idx = nth_tid(0, 0);
    check_eq("d_found", (idx >= 0), 1);
    if (idx >= 0) check_eq("d_pc", log_q[idx].pc, 16'h0040);
    check_seq("d_seq_t1", 1, 16'h8000);

    // Redirect clears a pending prefix
    mem[0] = 16'hF005; mem[16'h0100] = 16'h8002;
    do_reset();
    run(2);
    cycle(0, 1, 0, 16'h0100, 2'b00, 0);
    run(6);
    idx = nth_tid(0, 0);
    check_eq("e_found", (idx >= 0), 1);
    if (idx >= 0) begin
      check_eq("e_pc", log_q[idx].pc, 16'h0100);
      check_eq("e_immed", log_q[idx].imm, 16'h0002);
    end
    fill_base();

    // Halts
    do_reset();
    run(4);
    cycle(0, 0, 0, 16'h0, 2'b01, 0);
    hcyc = cyc;
    run(8);
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].cyc > hcyc && log_q[i].tid == 0) cnt++;
    check_eq("f_t0_bubbles", cnt, 0);
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].cyc > hcyc && log_q[i].tid == 1) cnt++;
    check_eq("f_t1_runs", (cnt >= 3), 1);
    cycle(0, 0, 0, 16'h0, 2'b10, 0);
    check_eq("f_halted", bus.halted, 1);
    run(2);
    do_reset();
    check_eq("f_unhalted", bus.halted, 0);
    run(4);
    check_eq("f_count", (log_q.size() >= 2), 1);
    if (log_q.size() >= 2) begin
      check_eq("f_pc0", log_q[0].pc, 16'h0000);
      check_eq("f_pc1", log_q[1].pc, 16'h8000);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 65536; k++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h8;
      mem[k] = w;
    end
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] hr;
      hr[0] = ($urandom_range(0, 399) == 0);
      hr[1] = ($urandom_range(0, 399) == 0);
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 1)), 16'($urandom), hr,
            ($urandom_range(0, 149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
